// File: rtl/div_pkg.sv
// Shared types and helpers for the divider request front-end.
// Helpers work at MAX_W bits; callers slice down to their own width.
package div_pkg;

  localparam int MAX_W = 128;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_FIXUP,
    ST_RESP
  } div_state_e;

  function automatic logic [MAX_W-1:0] neg2c(input logic [MAX_W-1:0] x);
    return ~x + MAX_W'(1);
  endfunction

  // Most negative value of a w-bit two's-complement number
  function automatic logic [MAX_W-1:0] min_val(input int unsigned w);
    return MAX_W'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/div_result_cache.sv
// One-entry quotient/remainder cache keyed on {a, b, unsigned flag}.
// Cleared only by reset; each write overwrites the single entry.
module div_result_cache #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_wr_en,
  input  logic [W-1:0] i_wr_a,
  input  logic [W-1:0] i_wr_b,
  input  logic         i_wr_uns,
  input  logic [W-1:0] i_wr_q,
  input  logic [W-1:0] i_wr_r,
  input  logic [W-1:0] i_lk_a,
  input  logic [W-1:0] i_lk_b,
  input  logic         i_lk_uns,
  output logic         o_hit,
  output logic [W-1:0] o_q,
  output logic [W-1:0] o_r
);

  logic         r_vld;
  logic [W-1:0] r_a, r_b, r_q, r_r;
  logic         r_uns;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= 1'b0;
      r_a   <= '0;
      r_b   <= '0;
      r_uns <= 1'b0;
      r_q   <= '0;
      r_r   <= '0;
    end else if (i_wr_en) begin
      r_vld <= 1'b1;
      r_a   <= i_wr_a;
      r_b   <= i_wr_b;
      r_uns <= i_wr_uns;
      r_q   <= i_wr_q;
      r_r   <= i_wr_r;
    end
  end

  assign o_hit = r_vld && (r_a == i_lk_a) && (r_b == i_lk_b) && (r_uns == i_lk_uns);
  assign o_q   = r_q;
  assign o_r   = r_r;

endmodule

// File: rtl/div_issue_ctrl.sv
// Divide/remainder front-end: special cases, sign handling and result reuse
// around an unsigned iterative divider. One request in flight at a time.
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int PARALLELISM = 32,
  parameter int TAG_W       = 4,
  parameter bit REUSE_EN    = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [PARALLELISM-1:0] req_a,
  input  logic [PARALLELISM-1:0] req_b,
  input  logic [TAG_W-1:0]       req_tag,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [PARALLELISM-1:0] rsp_data,
  output logic [TAG_W-1:0]       rsp_tag,
  output logic                   div_valid,
  output logic [PARALLELISM-1:0] div_dividend,
  output logic [PARALLELISM-1:0] div_divisor,
  input  logic [PARALLELISM-1:0] div_quotient,
  input  logic [PARALLELISM-1:0] div_reminder,
  input  logic                   div_res_ready,
  output logic                   busy
);

  localparam int W  = PARALLELISM;
  localparam int HW = MAX_W - W;
  localparam logic [MAX_W-1:0] MIN_X = min_val(W);
  localparam logic [W-1:0]     MIN_V = MIN_X[W-1:0];

  div_state_e     r_state, w_state_nxt;
  div_op_e        r_op;
  logic [W-1:0]   r_a, r_b, r_res, r_dvd, r_dvs;
  logic [TAG_W-1:0] r_tag;
  logic           r_sa, r_sb;

  logic           w_acc, w_sa, w_sb, w_bzero, w_ovf, w_hit, w_hit_raw, w_fast;
  logic [W-1:0]   w_hit_q, w_hit_r, w_fast_res;
  logic [W-1:0]   w_neg_a, w_neg_b, w_neg_q, w_neg_r, w_fix_q, w_fix_r;
  logic [HW-1:0]  w_unused_na, w_unused_nb, w_unused_nq, w_unused_nr;

  assign {w_unused_na, w_neg_a} = neg2c(MAX_W'(req_a));
  assign {w_unused_nb, w_neg_b} = neg2c(MAX_W'(req_b));
  assign {w_unused_nq, w_neg_q} = neg2c(MAX_W'(div_quotient));
  assign {w_unused_nr, w_neg_r} = neg2c(MAX_W'(div_reminder));

  assign w_acc   = req_valid && (r_state == ST_IDLE);
  assign w_sa    = req_a[W-1] & ~req_op[0];
  assign w_sb    = req_b[W-1] & ~req_op[0];
  assign w_bzero = (req_b == '0);
  assign w_ovf   = ~req_op[0] && (req_a == MIN_V) && (&req_b);
  assign w_hit   = REUSE_EN && w_hit_raw;
  assign w_fast  = w_bzero || w_ovf || w_hit;

  div_result_cache #(.W(W)) u_cache (
    .clk      (clk),
    .rst      (rst),
    .i_wr_en  (REUSE_EN && (r_state == ST_FIXUP)),
    .i_wr_a   (r_a),
    .i_wr_b   (r_b),
    .i_wr_uns (r_op[0]),
    .i_wr_q   (w_fix_q),
    .i_wr_r   (w_fix_r),
    .i_lk_a   (req_a),
    .i_lk_b   (req_b),
    .i_lk_uns (req_op[0]),
    .o_hit    (w_hit_raw),
    .o_q      (w_hit_q),
    .o_r      (w_hit_r)
  );

  // Results that never touch the divider, in priority order
  always_comb begin
    w_fast_res = req_op[1] ? w_hit_r : w_hit_q;
    if (w_bzero)    w_fast_res = req_op[1] ? req_a : '1;
    else if (w_ovf) w_fast_res = req_op[1] ? '0 : MIN_V;
  end

  assign w_fix_q = (r_sa ^ r_sb) ? w_neg_q : div_quotient;
  assign w_fix_r = r_sa ? w_neg_r : div_reminder;

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    div_valid   = 1'b0;
    rsp_valid   = 1'b0;
    busy        = 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) w_state_nxt = w_fast ? ST_RESP : ST_LAUNCH;
      end
      ST_LAUNCH: begin
        div_valid   = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT:  if (div_res_ready) w_state_nxt = ST_FIXUP;
      ST_FIXUP: w_state_nxt = ST_RESP;
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op  <= OP_DIV;
      r_a   <= '0;
      r_b   <= '0;
      r_tag <= '0;
      r_sa  <= 1'b0;
      r_sb  <= 1'b0;
      r_res <= '0;
      r_dvd <= '0;
      r_dvs <= '0;
    end else begin
      if (w_acc) begin
        r_op  <= div_op_e'(req_op);
        r_a   <= req_a;
        r_b   <= req_b;
        r_tag <= req_tag;
        r_sa  <= w_sa;
        r_sb  <= w_sb;
        if (w_fast) begin
          r_res <= w_fast_res;
        end else begin
          r_dvd <= w_sa ? w_neg_a : req_a;
          r_dvs <= w_sb ? w_neg_b : req_b;
        end
      end
      if (r_state == ST_FIXUP) r_res <= r_op[1] ? w_fix_r : w_fix_q;
    end
  end

  assign rsp_data     = r_res;
  assign rsp_tag      = r_tag;
  assign div_dividend = r_dvd;
  assign div_divisor  = r_dvs;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a fixed-latency unsigned divider model.
module tb_div_issue_ctrl;

  localparam int W   = 32;
  localparam int TW  = 4;
  localparam int LAT = 3;          // launch pulse to div_res_ready, in cycles
  localparam int DLAT = 3 + LAT;   // accept to rsp_valid on the divider path

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0, req_ready;
  logic [1:0]    req_op = '0;
  logic [W-1:0]  req_a = '0, req_b = '0;
  logic [TW-1:0] req_tag = '0;
  logic          rsp_valid, rsp_ready = 1'b1;
  logic [W-1:0]  rsp_data;
  logic [TW-1:0] rsp_tag;
  logic          div_valid;
  logic [W-1:0]  div_dividend, div_divisor, div_quotient, div_reminder;
  logic          div_res_ready;
  logic          busy;

  int total = 0;
  int bad   = 0;

  div_issue_ctrl #(.PARALLELISM(W), .TAG_W(TW), .REUSE_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .div_valid(div_valid), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_reminder(div_reminder),
    .div_res_ready(div_res_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Unsigned divider model: result held until the next launch
  logic [W-1:0] m_q = '0, m_r = '0, last_dvd = '0, last_dvs = '0;
  logic         m_rdy = 1'b0;
  int           m_cnt = 0;
  int           n_launch = 0;

  always @(posedge clk) begin
    if (div_valid) begin
      n_launch <= n_launch + 1;
      last_dvd <= div_dividend;
      last_dvs <= div_divisor;
      m_q      <= div_dividend / div_divisor;
      m_r      <= div_dividend % div_divisor;
      m_rdy    <= 1'b0;
      m_cnt    <= LAT - 1;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_rdy <= 1'b1;
    end
  end

  assign div_res_ready = m_rdy;
  assign div_quotient  = m_rdy ? m_q : 32'hDEAD_BEEF;
  assign div_reminder  = m_rdy ? m_r : 32'hBEEF_DEAD;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_req(input string nm, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [TW-1:0] tag,
                        input logic [W-1:0] exp, input int lat, input int nl,
                        input logic [W-1:0] dvd, input logic [W-1:0] dvs);
    int k, l0;
    bit got;
    @(negedge clk);
    k = 0;
    while (!req_ready && k < 50) begin @(negedge clk); k++; end
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    rsp_ready = 1'b1;
    l0 = n_launch;
    @(posedge clk); #1 req_valid = 1'b0;
    k = 0; got = 1'b0;
    while (!got && k < 50) begin @(negedge clk); k++; got = rsp_valid; end
    chk({nm, "/valid"},   32'(got), 32'd1);
    chk({nm, "/latency"}, 32'(k), 32'(lat));
    chk({nm, "/data"},    rsp_data, exp);
    chk({nm, "/tag"},     32'(rsp_tag), 32'(tag));
    chk({nm, "/launches"}, 32'(n_launch - l0), 32'(nl));
    if (nl > 0) begin
      chk({nm, "/dividend"}, last_dvd, dvd);
      chk({nm, "/divisor"},  last_dvs, dvs);
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    string       nm;
    logic [1:0]  op;
    logic [31:0] a, b, exp, dvd, dvs;
    int          lat, nl;
  } vec_t;

  vec_t tbl[16];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{"div_neg7_2",    2'b00, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'd7,        32'd2,        DLAT, 1};
    tbl[1]  = '{"rem_neg7_2_hit",2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'd0,        32'd0,        1,    0};
    tbl[2]  = '{"divu_f9_2",     2'b01, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 32'hFFFFFFF9, 32'd2,        DLAT, 1};
    tbl[3]  = '{"rem_sign_miss", 2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'd7,        32'd2,        DLAT, 1};
    tbl[4]  = '{"div_by_zero",   2'b00, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd0,        32'd0,        1,    0};
    tbl[5]  = '{"remu_by_zero",  2'b11, 32'd5,        32'd0,        32'd5,        32'd0,        32'd0,        1,    0};
    tbl[6]  = '{"div_ovf",       2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        32'd0,        1,    0};
    tbl[7]  = '{"rem_ovf",       2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'd0,        32'd0,        1,    0};
    tbl[8]  = '{"divu_min_ff",   2'b01, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 32'hFFFFFFFF, DLAT, 1};
    tbl[9]  = '{"remu_min_hit",  2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        32'd0,        1,    0};
    tbl[10] = '{"div_m100_7",    2'b00, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'd100,      32'd7,        DLAT, 1};
    tbl[11] = '{"rem_m100_hit",  2'b10, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 32'd0,        32'd0,        1,    0};
    tbl[12] = '{"div_100_m7",    2'b00, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd100,      32'd7,        DLAT, 1};
    tbl[13] = '{"rem_100_m7_hit",2'b10, 32'd100,      32'hFFFFFFF9, 32'd2,        32'd0,        32'd0,        1,    0};
    tbl[14] = '{"div_min_2",     2'b00, 32'h80000000, 32'd2,        32'hC0000000, 32'h80000000, 32'd2,        DLAT, 1};
    tbl[15] = '{"rem_min_2_hit", 2'b10, 32'h80000000, 32'd2,        32'd0,        32'd0,        32'd0,        1,    0};

    // Reset state
    @(negedge clk);
    chk("rst/rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst/div_valid", 32'(div_valid), 32'd0);
    chk("rst/rsp_data",  rsp_data, 32'd0);
    chk("rst/rsp_tag",   32'(rsp_tag), 32'd0);
    chk("rst/dividend",  div_dividend, 32'd0);
    chk("rst/divisor",   div_divisor, 32'd0);
    chk("rst/busy",      32'(busy), 32'd0);
    chk("rst/req_ready", 32'(req_ready), 32'd1);
    rst = 1'b0;

    for (int i = 0; i < 16; i++)
      do_req(tbl[i].nm, tbl[i].op, tbl[i].a, tbl[i].b, 4'(i), tbl[i].exp,
             tbl[i].lat, tbl[i].nl, tbl[i].dvd, tbl[i].dvs);

    // Backpressure: DIV 100/7 held for 5 cycles, then back-to-back REM hit
    begin
      int k;
      @(negedge clk);
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_op = 2'b00; req_a = 32'd100; req_b = 32'd7; req_tag = 4'hA;
      @(posedge clk); #1 req_valid = 1'b0;
      k = 0;
      while (!rsp_valid && k < 50) begin @(negedge clk); k++; end
      chk("bp/latency", 32'(k), 32'(DLAT));
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        chk("bp/hold_valid", 32'(rsp_valid), 32'd1);
        chk("bp/hold_data",  rsp_data, 32'd14);
        chk("bp/hold_tag",   32'(rsp_tag), 32'hA);
        chk("bp/req_ready",  32'(req_ready), 32'd0);
      end
      req_valid = 1'b1; req_op = 2'b10; req_tag = 4'hB;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp/consumed",   32'(rsp_valid), 32'd0);
      chk("bp/ready_next", 32'(req_ready), 32'd1);
      @(posedge clk); #1 req_valid = 1'b0;
      @(negedge clk);
      chk("bp/next_valid", 32'(rsp_valid), 32'd1);
      chk("bp/next_data",  rsp_data, 32'd2);
      chk("bp/next_tag",   32'(rsp_tag), 32'hB);
      @(posedge clk); #1;
    end

    // Reset while waiting on the divider; stale ready must not finish the next op
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b00; req_a = 32'd200; req_b = 32'd7; req_tag = 4'h3;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid/busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid/busy",      32'(busy), 32'd0);
    chk("mid/rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid/stale_idle", 32'(rsp_valid), 32'd0);
    do_req("post_rst_div", 2'b00, 32'd100, 32'd7, 4'h5, 32'd14, DLAT, 1, 32'd100, 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- Request front-end for the iterative divider; sits directly upstream of it and owns the divide/remainder operation semantics.
- Accepts DIV/DIVU/REM/REMU requests over valid/ready and resolves divide-by-zero and signed overflow locally.
- Converts signed operands to magnitudes, launches the divider, applies sign fix-up and result selection, and returns the result over valid/ready.
- Keeps a one-entry quotient/remainder cache so a REM following a DIV on the same operands (or the reverse) skips the divider.

Parameters:
- PARALLELISM, 32, operand/result width; must equal the divider's width.
- TAG_W, 4, width of the opaque request tag echoed on the response.
- REUSE_EN, 1, 1 enables the result cache, 0 forces every non-special request through the divider.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (bit0 = unsigned, bit1 = remainder)
- req_a  in  PARALLELISM  dividend
- req_b  in  PARALLELISM  divisor
- req_tag  in  TAG_W  echoed tag
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_data  out  PARALLELISM  quotient or remainder
- rsp_tag  out  TAG_W  tag of the request
- div_valid  out  1  one-cycle launch pulse to the divider
- div_dividend  out  PARALLELISM  dividend magnitude
- div_divisor  out  PARALLELISM  divisor magnitude
- div_quotient  in  PARALLELISM  unsigned quotient from the divider
- div_reminder  in  PARALLELISM  unsigned remainder from the divider
- div_res_ready  in  1  divider result valid; held until the next launch
- busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset: state IDLE; rsp_valid=0, div_valid=0, rsp_data=0, rsp_tag=0, div_dividend=0, div_divisor=0, cache valid=0.
- The divider is instantiated in unsigned mode; all sign handling is done in this block.
- FSM states: IDLE, LAUNCH, WAIT, FIXUP, RESP.
- req_ready = (state==IDLE). On accept, latch op, a, b, tag, sa=a[MSB]&~op0, sb=b[MSB]&~op0.
- Accept in IDLE, by priority:
  - b==0: result Q=all-ones, R=a; go to RESP.
  - Signed op, a==MIN (1 followed by zeros), b==all-ones: Q=MIN, R=0; go to RESP.
  - REUSE_EN and cache hit (cache valid, a, b and op0 all match): take Q/R from the cache; go to RESP.
  - Otherwise go to LAUNCH.
- LAUNCH: div_valid=1 for exactly one cycle. div_dividend=sa ? -a : a, div_divisor=sb ? -b : b. Both are held stable until FIXUP. Go to WAIT.
- WAIT: stay until div_res_ready==1. A div_res_ready level still asserted from the previous operation during the LAUNCH cycle is ignored; only WAIT samples it. Go to FIXUP.
- FIXUP (1 cycle):
  - Q = (sa^sb) ? -div_quotient : div_quotient.
  - R = sa ? -div_reminder : div_reminder.
  - Write {a, b, op0, Q, R} to the cache and set it valid. Go to RESP.
  - Special-case results never update the cache.
- RESP: rsp_valid=1, rsp_data = op1 ? R : Q, rsp_tag = latched tag. rsp_data and rsp_tag stay stable while rsp_valid && !rsp_ready. Go to IDLE on rsp_ready.
- Latency from accept cycle T to rsp_valid:
  - Special case or cache hit: T+1.
  - Divider path: T+3+N, where N is the number of cycles from the launch pulse to div_res_ready.
- Throughput: one request in flight. The earliest next accept is the cycle after the response handshake.
- All negation is two's complement modulo 2^PARALLELISM, so -MIN = MIN and is handled as a magnitude.
- rst asserted mid-operation: return to IDLE immediately and invalidate the cache. Any divider result arriving afterwards is ignored, because only WAIT samples div_res_ready.
- div_valid is never asserted outside LAUNCH.

Decomposition:
- Shared package div_pkg:
  - op encoding enum: DIV, DIVU, REM, REMU.
  - FSM state enum.
  - Helper functions for two's-complement negate and the MIN constant, parameterised by width.
- One natural sub-module: div_result_cache, the one-entry tag/data register with hit compare and write port.
- Everything else (FSM, sign handling, special cases, response register) stays inline.

Test Plan:
- DIV a=-7 (0xFFFFFFF9), b=2 -> div_dividend=7, div_divisor=2; rsp_data=0xFFFFFFFD (-3). Then REM with the same operands -> rsp_data=0xFFFFFFFF (-1) at T+1 with no div_valid pulse (cache hit).
- DIVU a=0xFFFFFFF9, b=2 -> rsp_data=0x7FFFFFFC. Follow with REM (signed) on the same operands -> cache miss, divider launched, rsp_data=0xFFFFFFFF.
- DIV a=5, b=0 -> rsp_data=0xFFFFFFFF at T+1. REMU a=5, b=0 -> rsp_data=5. div_valid never asserted in either case.
- DIV a=0x80000000, b=0xFFFFFFFF -> rsp_data=0x80000000. REM with the same operands -> rsp_data=0. No divider launch.
- Backpressure: hold rsp_ready=0 for 5 cycles on a DIV 100/7 -> rsp_data=14 and rsp_tag stay stable and req_ready=0 throughout; on release, a new request is accepted the next cycle.
- Reset pulse while in WAIT, then DIV 100/7 -> fresh launch with no cache hit, result 14; the stale div_res_ready from before reset does not complete the new request early.
